mac_lookup_req: RTL and testbench
=================================

Name: mac_lookup_req

Overview:
Ingress-side requester for the MAC learning/lookup table. Parses the first 12 bytes of each frame on one ingress byte stream and extracts DA and SA. Folds each address to a table index and issues one combined learn (SA→ingress port) plus lookup (DA) request. Waits the table's read latency and returns the egress port decision to the switch fabric over a valid/ready handshake.

Parameters:
pNUM_PORTS, 4, number of switch ports; port fields are $clog2(pNUM_PORTS) bits (PW).
pADDR_WIDTH, 14, table index width (AW).
pLK_LAT, 2, cycles from request strobe to valid table read data; legal range 1..7.

Ports:
iclk  in  1  clock
irst  in  1  asynchronous active-high reset
ipnum  in  PW  ingress port number, sampled on the SOF byte
idata  in  8  frame byte, DA MSB first
ivalid  in  1  idata valid
isof  in  1  first byte of frame; qualified by ivalid
ieof  in  1  last byte of frame; qualified by ivalid
osa  out  AW  folded SA index to table
oda  out  AW  folded DA index to table
opnum  out  PW  ingress port written with SA
owr_en  out  1  one-cycle request/learn strobe
ilk_pnum  in  PW  table result port for oda
ilk_hit  in  1  table entry for oda is live (age != 0)
odec_pnum  out  PW  egress port decision
odec_flood  out  1  1 = flood to all ports except ingress; odec_pnum then holds the ingress port
odec_valid  out  1  decision valid
idec_ready  in  1  fabric accepts decision
oframe_drop  out  1  one-cycle pulse per frame discarded

Behaviour:
- Reset (async, any state) → IDLE. All outputs 0. Byte counter 0. Address shift registers 0.
- FSM states: IDLE, HDR, REQ, WAIT, RESP.
- IDLE: on ivalid&isof → latch ipnum, shift byte into the DA register, counter=1, go to HDR.
- HDR: each ivalid byte shifts into the DA register (count 0-5) or the SA register (count 6-11). Counter increments. Gaps with ivalid=0 are allowed.
  - When byte 11 is taken → REQ.
  - ivalid&ieof before byte 11 (runt) → pulse oframe_drop and go to IDLE. No request is issued.
  - ivalid&isof while in HDR → restart capture with this byte as byte 0. Pulse oframe_drop for the abandoned frame.
- Fold function: split the 48-bit MAC into AW-bit chunks from the LSB. Zero-pad the last partial chunk. XOR all chunks. For AW=14: bits[13:0]^[27:14]^[41:28]^{8'b0,[47:42]}.
- REQ (1 cycle): drive oda, osa and opnum; owr_en=1. These outputs stay stable until the next REQ. Load the latency counter with pLK_LAT → WAIT.
- WAIT: count down. When the counter reaches 0, sample ilk_pnum and ilk_hit → RESP.
  - Sample rule: the sample is taken exactly pLK_LAT cycles after the owr_en cycle.
- Decision computed at the WAIT→RESP sample:
  - miss (ilk_hit=0) → flood=1.
  - hit with ilk_pnum==ingress → drop: pulse oframe_drop, no decision, go to IDLE.
  - otherwise → flood=0, odec_pnum=ilk_pnum.
- RESP: odec_valid=1, decision held stable until odec_valid&idec_ready. Then odec_valid=0 next cycle → IDLE.
  - Accept and a new isof may occur in the same cycle: that byte is consumed as byte 0 and the FSM goes directly to HDR.
- Bytes arriving in REQ/WAIT/RESP (including the remaining payload) are ignored.
  - An isof seen in REQ/WAIT, or in RESP without accept, marks that frame dropped: pulse oframe_drop once per such SOF.
- Bytes after byte 11 up to ieof never affect state.
- Latency: ieof-independent. From the byte-11 cycle: REQ is next cycle; odec_valid rises pLK_LAT+2 cycles after byte 11.

Optional Feature:
MAC_LOOKUP_MCAST_EN.
- Defined: DA group bit (bit 0 of DA byte 0) =1 forces odec_flood=1 regardless of ilk_hit/ilk_pnum; the request is still issued.
  - SA group bit =1 suppresses learning: the REQ cycle still presents oda, but owr_en=0.
  - The response is still sampled pLK_LAT cycles later.
- Undefined: group bits are ignored; all addresses are handled as unicast.

Decomposition:
- Package mac_pkg:
  - MAC_W=48.
  - Port-width and index-width localparam helpers.
  - State enum typedef.
  - mac_fold function, shared with future table-side tooling.
- One sub-module, mac_hdr_capture: byte counter, DA/SA shift registers, runt/restart detection. Outputs a one-cycle hdr_done with both addresses and the ingress port.
- Request/wait/response FSM stays in the top.

Test Plan:
- DA 00:00:00:00:00:01, SA 00:00:00:00:00:05, ipnum=2, table hit port 3 → owr_en pulse with oda=0x0001, osa=0x0005, opnum=2; odec_pnum=3, flood=0, valid pLK_LAT+2 after byte 11.
- DA FF:FF:FF:FF:FF:FF, table miss → oda=0x3FC0, odec_flood=1, odec_pnum=ingress.
- Hit with ilk_pnum==ipnum=1 → oframe_drop pulse, no odec_valid.
- ieof on byte 7 → oframe_drop, owr_en never asserted. Next full frame processed normally.
- idec_ready held 0 for 10 cycles with a second SOF at cycle 4 → decision stable throughout; one oframe_drop; accept on ready.
- irst asserted mid-WAIT → all outputs 0 immediately; a fresh frame after release yields a correct decision.

Source files
------------

// File: rtl/mac_lookup_req_pkg.sv
// mac_pkg: shared widths, state encoding and the MAC-to-index fold used by
// the ingress lookup requester (and by table-side tooling).
package mac_pkg;

   localparam int MAC_W = 48;
   localparam int LAT_W = 3;

   // Width of a port-number field for a switch with num_ports ports.
   function automatic int port_w(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // Width of a table index; kept as a helper so callers never hard-code it.
   function automatic int idx_w(input int addr_width);
      return (addr_width > 0) ? addr_width : 1;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } state_t;

   // XOR all aw-bit chunks of the MAC (LSB chunk first, last chunk zero
   // padded). Result sits in the low aw bits; upper bits stay zero.
   function automatic logic [MAC_W-1:0] mac_fold(input logic [MAC_W-1:0] mac,
                                                 input int aw);
      logic [MAC_W-1:0] acc;
      logic [5:0]       pos;
      logic [5:0]       src;
      acc = '0;
      for (int i = 0; i < MAC_W; i++) begin
         pos = 6'(i % aw);
         src = 6'(i);
         acc[pos] = acc[pos] ^ mac[src];
      end
      return acc;
   endfunction

endpackage

// File: rtl/mac_lookup_req_if.sv
// Ingress byte stream, table request/response and fabric decision signals
// of the MAC lookup requester, bundled for connection to the top.
interface mac_lookup_req_if #(
   parameter int PW = 2,
   parameter int AW = 14
);
   logic [PW-1:0] ipnum;
   logic [7:0]    idata;
   logic          ivalid;
   logic          isof;
   logic          ieof;
   logic [AW-1:0] osa;
   logic [AW-1:0] oda;
   logic [PW-1:0] opnum;
   logic          owr_en;
   logic [PW-1:0] ilk_pnum;
   logic          ilk_hit;
   logic [PW-1:0] odec_pnum;
   logic          odec_flood;
   logic          odec_valid;
   logic          idec_ready;
   logic          oframe_drop;

   // Requester side.
   modport slave (
      input  ipnum, idata, ivalid, isof, ieof, ilk_pnum, ilk_hit, idec_ready,
      output osa, oda, opnum, owr_en, odec_pnum, odec_flood, odec_valid,
      oframe_drop
   );

   // Environment side: ingress MAC, lookup table and fabric.
   modport master (
      output ipnum, idata, ivalid, isof, ieof, ilk_pnum, ilk_hit, idec_ready,
      input  osa, oda, opnum, owr_en, odec_pnum, odec_flood, odec_valid,
      oframe_drop
   );
endinterface

// File: rtl/mac_lookup_req_hdr_capture.sv
// mac_hdr_capture: collects DA (bytes 0-5) and SA (bytes 6-11) of a frame,
// flags runts and mid-header restarts, and pulses hdr_done on byte 11.
// The byte-11 cycle presents the complete SA combinationally so the request
// can be registered on the very next edge.
module mac_hdr_capture
   import mac_pkg::*;
#(
   parameter int PW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_ok,
   input  logic [PW-1:0]    ipnum,
   input  logic [7:0]       idata,
   input  logic             ivalid,
   input  logic             isof,
   input  logic             ieof,
   output logic             hdr_start,
   output logic             hdr_done,
   output logic             hdr_drop,
   output logic [MAC_W-1:0] da,
   output logic [MAC_W-1:0] sa,
   output logic [PW-1:0]    pnum
);

   logic             busy;
   logic [3:0]       cnt;
   logic [MAC_W-1:0] da_sr;
   logic [MAC_W-9:0] sa_sr;
   logic [PW-1:0]    pnum_q;
   logic             sof_v;
   logic             sof_take;
   logic             runt;

   assign sof_v     = ivalid & isof;
   assign sof_take  = sof_v & (start_ok | busy);
   assign hdr_start = sof_take & ~ieof;
   assign hdr_done  = busy & ivalid & ~isof & (cnt == 4'd11);
   assign runt      = busy & ivalid & ~isof & ieof & (cnt != 4'd11);
   // A one-byte frame is a runt too; a restart abandons the frame in flight.
   assign hdr_drop  = runt | (busy & sof_v) | (sof_take & ieof & ~busy);

   assign da   = da_sr;
   assign sa   = {sa_sr, idata};
   assign pnum = pnum_q;

   // Byte counter and DA/SA shift registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         da_sr  <= '0;
         sa_sr  <= '0;
         pnum_q <= '0;
      end else if (sof_take) begin
         busy   <= ~ieof;
         cnt    <= {3'b000, ~ieof};
         da_sr  <= {da_sr[MAC_W-9:0], idata};
         pnum_q <= ipnum;
      end else if (busy && ivalid) begin
         if (ieof || cnt == 4'd11) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 4'd1;
            if (cnt < 4'd6) da_sr <= {da_sr[MAC_W-9:0], idata};
            else            sa_sr <= {sa_sr[MAC_W-17:0], idata};
         end
      end
   end

endmodule

// File: rtl/mac_lookup_req.sv
// mac_lookup_req: ingress-side requester for the MAC learning/lookup table.
// Captures DA/SA, issues a combined learn+lookup request, waits pLK_LAT
// cycles for the table read and hands the egress decision to the fabric.
// Optional build macro MAC_LOOKUP_MCAST_EN: group DA forces flood, group SA
// suppresses the learn strobe.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a SOF byte
// HDR     | capturing header bytes 1..11
// REQ     | request strobe cycle, load latency counter
// WAIT    | counting down table read latency
// RESP    | decision presented, waiting for fabric accept
module mac_lookup_req
   import mac_pkg::*;
#(
   parameter int pNUM_PORTS  = 4,
   parameter int pADDR_WIDTH = 14,
   parameter int pLK_LAT     = 2
) (
   input  logic iclk,
   input  logic irst,
   mac_lookup_req_if.slave bus
);

   localparam int PW = port_w(pNUM_PORTS);
   localparam int AW = idx_w(pADDR_WIDTH);

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic             mc_da;
   logic             start_ok;
   logic             sof_ignored;
   logic             hdr_start;
   logic             hdr_done;
   logic             hdr_drop;
   logic [MAC_W-1:0] hdr_da;
   logic [MAC_W-1:0] hdr_sa;
   logic [PW-1:0]    hdr_pnum;
   logic             da_group;
   logic             sa_group;

`ifdef MAC_LOOKUP_MCAST_EN
   assign da_group = hdr_da[40];
   assign sa_group = hdr_sa[40];
`else
   assign da_group = 1'b0;
   assign sa_group = 1'b0;
`endif

   // A new frame may start from IDLE, or in the same cycle a decision is accepted.
   assign start_ok    = (state == ST_IDLE) | ((state == ST_RESP) & bus.idec_ready);
   assign sof_ignored = bus.ivalid & bus.isof &
                        ((state == ST_REQ) | (state == ST_WAIT) |
                         ((state == ST_RESP) & ~bus.idec_ready));

   mac_hdr_capture #(.PW(PW)) u_hdr (
      .clk      (iclk),
      .rst      (irst),
      .start_ok (start_ok),
      .ipnum    (bus.ipnum),
      .idata    (bus.idata),
      .ivalid   (bus.ivalid),
      .isof     (bus.isof),
      .ieof     (bus.ieof),
      .hdr_start(hdr_start),
      .hdr_done (hdr_done),
      .hdr_drop (hdr_drop),
      .da       (hdr_da),
      .sa       (hdr_sa),
      .pnum     (hdr_pnum)
   );

   // Request/wait/response FSM with registered outputs.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state           <= ST_IDLE;
         lat_cnt         <= '0;
         mc_da           <= 1'b0;
         bus.osa         <= '0;
         bus.oda         <= '0;
         bus.opnum       <= '0;
         bus.owr_en      <= 1'b0;
         bus.odec_pnum   <= '0;
         bus.odec_flood  <= 1'b0;
         bus.odec_valid  <= 1'b0;
         bus.oframe_drop <= 1'b0;
      end else begin
         bus.owr_en      <= 1'b0;
         bus.oframe_drop <= hdr_drop | sof_ignored;
         case (state)
            ST_IDLE: begin
               if (hdr_start) state <= ST_HDR;
            end
            ST_HDR: begin
               if (hdr_done) begin
                  bus.oda    <= AW'(mac_fold(hdr_da, AW));
                  bus.osa    <= AW'(mac_fold(hdr_sa, AW));
                  bus.opnum  <= hdr_pnum;
                  bus.owr_en <= ~sa_group;
                  mc_da      <= da_group;
                  state      <= ST_REQ;
               end else if (hdr_drop && !hdr_start) begin
                  state <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // Terminal count 0 lands the sample pLK_LAT cycles after the strobe.
               lat_cnt <= LAT_W'(pLK_LAT - 1);
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end else if (mc_da || !bus.ilk_hit) begin
                  bus.odec_flood <= 1'b1;
                  bus.odec_pnum  <= bus.opnum;
                  bus.odec_valid <= 1'b1;
                  state          <= ST_RESP;
               end else if (bus.ilk_pnum == bus.opnum) begin
                  bus.oframe_drop <= 1'b1;
                  state           <= ST_IDLE;
               end else begin
                  bus.odec_flood <= 1'b0;
                  bus.odec_pnum  <= bus.ilk_pnum;
                  bus.odec_valid <= 1'b1;
                  state          <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.idec_ready) begin
                  bus.odec_valid <= 1'b0;
                  state          <= hdr_start ? ST_HDR : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_lookup_req.sv
// Scoreboard bench for mac_lookup_req: stimulus pushes expected requests and
// decisions, a negedge monitor pops and compares them, and a small table
// model returns valid data only in the cycle the requester must sample it.
module tb_mac_lookup_req;
   localparam int LAT = 2;

   typedef struct {
      logic [13:0] da;
      logic [13:0] sa;
      logic [1:0]  pnum;
   } req_t;

   typedef struct {
      logic [1:0] pnum;
      logic       flood;
      int         cyc;
   } dec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   drop_seen = 0;
   int   exp_drop = 0;
   logic tbl_hit = 1'b0;
   logic [1:0] tbl_pnum = 2'd0;
   logic [7:0] sr = 8'd0;
   logic prev_valid = 1'b0;
   req_t req_q[$];
   dec_t dec_q[$];

   mac_lookup_req_if #(.PW(2), .AW(14)) bif();

   mac_lookup_req #(
      .pNUM_PORTS (4),
      .pADDR_WIDTH(14),
      .pLK_LAT    (LAT)
   ) dut (
      .iclk(clk),
      .irst(rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Table model: good data only in the sample cycle, junk elsewhere.
   initial forever begin
      @(negedge clk);
      if (rst) sr = 8'd0;
      else     sr = {sr[6:0], bif.owr_en};
      if (sr[LAT]) begin
         bif.ilk_hit  = tbl_hit;
         bif.ilk_pnum = tbl_pnum;
      end else begin
         bif.ilk_hit  = ~tbl_hit;
         bif.ilk_pnum = tbl_pnum ^ 2'b01;
      end
   end

   // Monitor: compares requests, decisions (every valid cycle) and counts drops.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (bif.owr_en) begin
            if (req_q.size() == 0) begin
               chk("req_unexpected", int'(bif.owr_en), 0);
            end else begin
               req_t r;
               r = req_q.pop_front();
               chk("req_oda", int'(bif.oda), int'(r.da));
               chk("req_osa", int'(bif.osa), int'(r.sa));
               chk("req_opnum", int'(bif.opnum), int'(r.pnum));
            end
         end
         if (bif.oframe_drop) drop_seen++;
         if (bif.odec_valid) begin
            if (dec_q.size() == 0) begin
               chk("dec_unexpected", int'(bif.odec_valid), 0);
            end else begin
               dec_t e;
               e = dec_q[0];
               if (!prev_valid) chk("dec_latency", cyc, e.cyc);
               chk("dec_pnum", int'(bif.odec_pnum), int'(e.pnum));
               chk("dec_flood", int'(bif.odec_flood), int'(e.flood));
               if (bif.idec_ready) void'(dec_q.pop_front());
            end
         end
         prev_valid = bif.odec_valid;
      end
   end

   task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                             input logic [1:0] pn, input int eof_idx,
                             input int gap_at, output int b11_cyc);
      logic [7:0] b;
      b11_cyc = -1;
      for (int i = 0; i <= eof_idx; i++) begin
         if (i == gap_at) begin
            @(posedge clk); #1;
            bif.ivalid = 1'b0;
            bif.isof   = 1'b0;
            bif.ieof   = 1'b0;
         end
         @(posedge clk); #1;
         if (i < 6)       b = da[47-8*i -: 8];
         else if (i < 12) b = sa[47-8*(i-6) -: 8];
         else             b = 8'(i);
         bif.ivalid = 1'b1;
         bif.isof   = (i == 0);
         bif.ieof   = (i == eof_idx);
         bif.idata  = b;
         bif.ipnum  = pn;
         if (i == 11) b11_cyc = cyc;
      end
      @(posedge clk); #1;
      bif.ivalid = 1'b0;
      bif.isof   = 1'b0;
      bif.ieof   = 1'b0;
   endtask

   task automatic run_frame(input logic [47:0] da, input logic [47:0] sa,
                            input logic [1:0] pn, input logic hit,
                            input logic [1:0] hpn, input int eof_idx,
                            input int gap_at, input logic want_req,
                            input logic [13:0] rda, input logic [13:0] rsa,
                            input logic want_dec, input logic [1:0] dpn,
                            input logic dfl, input int drops);
      int b11;
      tbl_hit  = hit;
      tbl_pnum = hpn;
      if (want_req) req_q.push_back('{rda, rsa, pn});
      send_frame(da, sa, pn, eof_idx, gap_at, b11);
      if (want_dec) dec_q.push_back('{dpn, dfl, b11 + LAT + 2});
      exp_drop += drops;
   endtask

   task automatic settle(input string nm);
      repeat (8) @(posedge clk);
      #1;
      chk({nm, "_drops"}, drop_seen, exp_drop);
      chk({nm, "_req_pending"}, req_q.size(), 0);
      chk({nm, "_dec_pending"}, dec_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      bif.ivalid     = 1'b0;
      bif.isof       = 1'b0;
      bif.ieof       = 1'b0;
      bif.idata      = 8'd0;
      bif.ipnum      = 2'd0;
      bif.idec_ready = 1'b1;
      #2;
      chk("rst_owr_en", int'(bif.owr_en), 0);
      chk("rst_odec_valid", int'(bif.odec_valid), 0);
      chk("rst_oframe_drop", int'(bif.oframe_drop), 0);
      chk("rst_oda", int'(bif.oda), 0);
      chk("rst_osa", int'(bif.osa), 0);
      chk("rst_opnum", int'(bif.opnum), 0);
      chk("rst_odec_pnum", int'(bif.odec_pnum), 0);
      chk("rst_odec_flood", int'(bif.odec_flood), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Unicast hit to port 3, with an idle gap inside the header.
      run_frame(48'h0000_0000_0001, 48'h0000_0000_0005, 2'd2, 1'b1, 2'd3, 13, 3,
                1'b1, 14'h0001, 14'h0005, 1'b1, 2'd3, 1'b0, 0);
      settle("t1");

      // Broadcast DA, table miss: flood with ingress port.
      run_frame(48'hFFFF_FFFF_FFFF, 48'h0000_1000_4003, 2'd1, 1'b0, 2'd1, 13, -1,
                1'b1, 14'h3FC0, 14'h0003, 1'b1, 2'd1, 1'b1, 0);
      settle("t2");

      // Hit on the ingress port: drop, no decision.
      run_frame(48'h0000_0000_0002, 48'h0000_0000_0007, 2'd1, 1'b1, 2'd1, 13, -1,
                1'b1, 14'h0002, 14'h0007, 1'b0, 2'd0, 1'b0, 1);
      settle("t3");

      // Runt ending on byte 7, then a normal frame.
      run_frame(48'h0000_0000_0001, 48'h0000_0000_0005, 2'd1, 1'b1, 2'd3, 7, -1,
                1'b0, 14'h0, 14'h0, 1'b0, 2'd0, 1'b0, 1);
      run_frame(48'h0000_0000_8000, 48'h0000_0000_000A, 2'd3, 1'b1, 2'd0, 13, -1,
                1'b1, 14'h0002, 14'h000A, 1'b1, 2'd0, 1'b0, 0);
      settle("t4");

      // Backpressure for 10 cycles with a SOF arriving during RESP.
      bif.idec_ready = 1'b0;
      run_frame(48'h0000_0000_0001, 48'h0000_0000_0005, 2'd0, 1'b1, 2'd2, 13, -1,
                1'b1, 14'h0001, 14'h0005, 1'b1, 2'd2, 1'b0, 0);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clk); #1;
         ok = bif.odec_valid;
      end
      chk("bp_valid_seen", int'(ok), 1);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            bif.ivalid = 1'b1;
            bif.isof   = 1'b1;
            bif.ieof   = 1'b0;
            bif.idata  = 8'h00;
            bif.ipnum  = 2'd1;
            exp_drop++;
         end else if (k == 5) begin
            bif.ivalid = 1'b0;
            bif.isof   = 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("bp_valid_held", int'(bif.odec_valid), 1);
      bif.idec_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_low", int'(bif.odec_valid), 0);
      settle("t5");

      // Reset during WAIT, then a fresh frame.
      run_frame(48'h0000_0000_8000, 48'h0000_0000_0005, 2'd2, 1'b1, 2'd0, 11, -1,
                1'b1, 14'h0002, 14'h0005, 1'b1, 2'd0, 1'b0, 0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("midrst_owr_en", int'(bif.owr_en), 0);
      chk("midrst_odec_valid", int'(bif.odec_valid), 0);
      chk("midrst_oframe_drop", int'(bif.oframe_drop), 0);
      chk("midrst_oda", int'(bif.oda), 0);
      chk("midrst_osa", int'(bif.osa), 0);
      chk("midrst_opnum", int'(bif.opnum), 0);
      chk("midrst_odec_pnum", int'(bif.odec_pnum), 0);
      chk("midrst_odec_flood", int'(bif.odec_flood), 0);
      dec_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_frame(48'hFFFF_FFFF_FFFF, 48'h0000_1000_4003, 2'd3, 1'b1, 2'd1, 13, -1,
                1'b1, 14'h3FC0, 14'h0003, 1'b1, 2'd1, 1'b0, 0);
      settle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
